// File: rtl/mux4_feeder_pkg.sv
// -----------------------------------------------------------------------------
// mux4_feeder_pkg
// Shared types and constants for the mux4_feeder block.
//
// Contents:
//   DEFAULT_WIDTH  default data word width
//   state_t        FSM state encoding (FILL, SCAN)
//   SEL_FIRST      first mux select value of a scan
//   SEL_LAST       last mux select value of a scan
//   sel_step()     next select value in scan order
//
// Configuration macro: MUX4_FEEDER_REVERSE_SCAN_EN
//   undefined : scan 00 -> 01 -> 10 -> 11
//   defined   : scan 11 -> 10 -> 01 -> 00
// The fill order (slot 0 first) does not depend on the macro.
// -----------------------------------------------------------------------------
package mux4_feeder_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        FILL = 1'b0,
        SCAN = 1'b1
    } state_t;

`ifdef MUX4_FEEDER_REVERSE_SCAN_EN
    localparam logic [1:0] SEL_FIRST = 2'b11;
    localparam logic [1:0] SEL_LAST  = 2'b00;
`else
    localparam logic [1:0] SEL_FIRST = 2'b00;
    localparam logic [1:0] SEL_LAST  = 2'b11;
`endif

    // Advance the mux select one position in scan order.
    function automatic logic [1:0] sel_step(input logic [1:0] sel);
`ifdef MUX4_FEEDER_REVERSE_SCAN_EN
        return sel - 2'd1;
`else
        return sel + 2'd1;
`endif
    endfunction

endpackage

// File: rtl/mux4_feeder_slot_bank.sv
// -----------------------------------------------------------------------------
// slot_bank
// Four WIDTH-bit registers written one at a time and read in parallel.
// Every output is a direct register output, so the mux data inputs only
// change on a write.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset, clears every slot
//   wr_en     write enable
//   wr_addr   2-bit slot address of the write
//   wr_data   word to write
//   slot0..3  slot contents
// -----------------------------------------------------------------------------
module slot_bank
    import mux4_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] slot0,
    output logic [WIDTH-1:0] slot1,
    output logic [WIDTH-1:0] slot2,
    output logic [WIDTH-1:0] slot3
);

    logic [WIDTH-1:0] slots [4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                slots[i] <= '0;
            end
        end else if (wr_en) begin
            slots[wr_addr] <= wr_data;
        end
    end

    assign slot0 = slots[0];
    assign slot1 = slots[1];
    assign slot2 = slots[2];
    assign slot3 = slots[3];

endmodule

// File: rtl/mux4_feeder.sv
// -----------------------------------------------------------------------------
// mux4_feeder
// Collects four upstream words into a slot bank (FILL), then steps the
// select of a downstream 4:1 mux through the slots as the consumer takes
// each word (SCAN). After the last slot is taken the block refills.
//
// Ports:
//   Clk       clock, rising edge
//   Reset     asynchronous active-high reset
//   InData    upstream word
//   InValid   InData valid
//   InReady   block accepts InData (high throughout FILL)
//   Flush     synchronous abort of the current fill or scan
//   Data0..3  slot contents, wired to the mux data inputs
//   Select    mux select
//   OutValid  selected mux output is valid (high throughout SCAN)
//   OutReady  consumer takes the selected word
//
// Configuration macro: MUX4_FEEDER_REVERSE_SCAN_EN reverses the scan
// order (see mux4_feeder_pkg).
// -----------------------------------------------------------------------------
module mux4_feeder
    import mux4_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] InData,
    input  logic             InValid,
    output logic             InReady,
    input  logic             Flush,
    output logic [WIDTH-1:0] Data0,
    output logic [WIDTH-1:0] Data1,
    output logic [WIDTH-1:0] Data2,
    output logic [WIDTH-1:0] Data3,
    output logic [1:0]       Select,
    output logic             OutValid,
    input  logic             OutReady
);

    state_t     state;
    logic [1:0] wptr;
    logic [1:0] sel;
    logic       in_ready;
    logic       out_valid;
    logic       wr_en;

    // A flush drops any word offered in the same cycle.
    assign wr_en = (state == FILL) && InValid && !Flush;

    slot_bank #(
        .WIDTH (WIDTH)
    ) u_slot_bank (
        .clk     (Clk),
        .rst     (Reset),
        .wr_en   (wr_en),
        .wr_addr (wptr),
        .wr_data (InData),
        .slot0   (Data0),
        .slot1   (Data1),
        .slot2   (Data2),
        .slot3   (Data3)
    );

    // Handshake flags are registered alongside the state so they switch on
    // the same edge as the state they describe.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= FILL;
            wptr      <= 2'd0;
            sel       <= SEL_FIRST;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (Flush) begin
            state     <= FILL;
            wptr      <= 2'd0;
            sel       <= SEL_FIRST;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (InValid) begin
                        // wptr wraps 3 -> 0 by itself on the final word.
                        wptr <= wptr + 2'd1;
                        if (wptr == 2'd3) begin
                            state     <= SCAN;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (OutReady) begin
                        if (sel == SEL_LAST) begin
                            state     <= FILL;
                            sel       <= SEL_FIRST;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            sel <= sel_step(sel);
                        end
                    end
                end
                default: begin
                    state     <= FILL;
                    wptr      <= 2'd0;
                    sel       <= SEL_FIRST;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign InReady  = in_ready;
    assign OutValid = out_valid;
    assign Select   = sel;

endmodule

// File: doc/mux4_feeder.md
MUX4_FEEDER -- requirements
Module: mux4_feeder

Interface
- REQ-001: Parameter WIDTH, default 32, is the data word width of every data port.
- REQ-002: Clk  input  1  is the single clock; all state updates on its rising edge.
- REQ-003: Reset  input  1  is the asynchronous, active-high reset.
- REQ-004: InData  input  WIDTH  is the upstream word to be loaded into the next free slot.
- REQ-005: InValid  input  1  means InData is valid this cycle.
- REQ-006: InReady  output  1  means the block accepts InData this cycle.
- REQ-007: Flush  input  1  is a synchronous abort of the current fill or scan.
- REQ-008: Data0, Data1, Data2, Data3  output  WIDTH each  are the slot contents that drive the 4:1 mux data inputs.
- REQ-009: Select  output  2  drives the 4:1 mux select input.
- REQ-010: OutValid  output  1  means the mux output selected by Select is valid for the consumer.
- REQ-011: OutReady  input  1  means the consumer takes the current mux output this cycle.

Function
- REQ-012: The block SHALL implement a two-state machine with states FILL and SCAN.
- REQ-013: In FILL, InReady SHALL be 1 and OutValid SHALL be 0.
- REQ-014: In FILL, a handshake (InValid&InReady) SHALL write InData to slot[wptr] and increment the 2-bit wptr.
- REQ-015: Accepting the handshake at wptr==3 SHALL set wptr to 0 and move the state to SCAN, so OutValid=1 on the next cycle (1-cycle latency).
- REQ-016: In SCAN, InReady SHALL be 0 and OutValid SHALL be 1; InValid SHALL be ignored and no slot SHALL be written.
- REQ-017: On entry to SCAN, Select SHALL equal SEL_FIRST.
- REQ-018: Each OutReady=1 cycle in SCAN SHALL advance Select one step; Select SHALL hold while OutReady=0.
- REQ-019: OutReady=1 while Select==SEL_LAST SHALL return the state to FILL, reload Select to SEL_FIRST, and leave the slot contents unchanged.
- REQ-020: OutReady while OutValid=0 SHALL have no effect.
- REQ-021: Flush=1 SHALL force FILL, wptr=0 and Select=SEL_FIRST on the next edge, leave the slots unchanged, and take priority over a simultaneous input or output handshake (the word is dropped).
- REQ-022: Data0..Data3 SHALL be direct register outputs and SHALL change only on slot writes.

Reset
- REQ-023: While Reset=1, the block SHALL hold: state=FILL, wptr=0, Select=SEL_FIRST, Data0..Data3=0, OutValid=0, InReady=1 (the reset is asynchronous).
- REQ-024: Reset mid-fill or mid-scan SHALL discard all progress; the first edge after release SHALL behave as a fresh FILL at wptr=0.

Configuration
- REQ-025: Macro MUX4_FEEDER_REVERSE_SCAN_EN SHALL select the scan order.
- REQ-026: Without the macro: SEL_FIRST=2'b00, SEL_LAST=2'b11, and Select increments.
- REQ-027: With the macro: SEL_FIRST=2'b11, SEL_LAST=2'b00, and Select decrements. Fill order is unaffected by the macro.

Structure
- REQ-028: Package mux4_feeder_pkg SHALL hold the state typedef (FILL, SCAN), the default WIDTH, and the SEL_FIRST/SEL_LAST constants (macro-dependent).
- REQ-029: Sub-module slot_bank SHALL hold the 4xWIDTH register bank with write enable, 2-bit write address, async reset and four parallel outputs.
- REQ-030: The FSM, wptr and Select logic SHALL reside in mux4_feeder.

Verification
- REQ-031: Reset, then feed F0F0F0F0, F8F8F8F8, FBFBFBFB, FFFFFFFF with OutReady=1 -> Data0..3 hold those values; OutValid rises 1 cycle after the 4th word; Select steps 00,01,10,11; OutValid=0 after 4 transfers.
- REQ-032: OutReady=0 for 3 cycles at Select=01 -> Select and OutValid are held; InReady=0 and InValid pulses do not change Data0..3.
- REQ-033: Flush asserted after 2 words, then 4 new words -> Data0/Data1 are overwritten first; OutValid is reached only after 4 post-flush words.
- REQ-034: Reset asserted mid-scan at Select=10 -> all outputs reach reset values immediately; the next fill starts at Data0.
- REQ-035: Build with MUX4_FEEDER_REVERSE_SCAN_EN, same stimulus as REQ-031 -> Select sequence is 11,10,01,00 and slot contents are identical.
- REQ-036: Flush and InValid asserted in the same cycle at wptr=3 -> the word is dropped, state=FILL, wptr=0.
